mux_scan_nto1: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer with a built-in channel scanner. It generalises the team's fixed 16-to-1 single-bit mux in channel count and data width, and registers its output. It adds an auto-scan mode that steps through every channel with a programmable dwell time and emits a sample strobe. It sits between a bank of status/data sources and a single-lane consumer such as a logger, serialiser or LED driver.

---
 rtl/mux_pkg.sv | 19 +
 rtl/mux_nto1.sv | 32 +++
 rtl/mux_scan_nto1.sv | 125 ++++++++++++
 tb/tb_mux_scan_nto1.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_pkg
// Description : Shared FSM state and mode encodings for the scanning
//               multiplexer family.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage : mux_pkg
`default_nettype wire

// File: rtl/mux_nto1.sv
`default_nettype none
// ============================================================================
// Module      : mux_nto1
// Description : Combinational N-to-1, W-bit selector with range flag. An
//               out-of-range index yields zero data and in_range = 0.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_nto1 #(
    parameter int NCH = 16,
    parameter int W   = 1,
    parameter int SELW = $clog2(NCH)
) (
    input  logic [NCH*W-1:0] in,
    input  logic [SELW-1:0]  idx,
    output logic [W-1:0]     data,
    output logic             in_range
);

    // Decoded compare loop keeps every slice in bounds for any NCH.
    always_comb begin
        data     = '0;
        in_range = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (idx == SELW'(k)) begin
                data     = in[k*W +: W];
                in_range = 1'b1;
            end
        end
    end

endmodule : mux_nto1
`default_nettype wire

// File: rtl/mux_scan_nto1.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_nto1
// Description : Registered N-channel, W-bit multiplexer with manual select
//               and a free-running channel scanner with programmable dwell.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_nto1
    import mux_pkg::*;
#(
    parameter int NCH     = 16,
    parameter int W       = 1,
    parameter int SELW    = $clog2(NCH),
    parameter int DWELL_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NCH*W-1:0]    in,
    input  logic [SELW-1:0]     sel,
    input  logic                mode,
    input  logic                start,
    input  logic [DWELL_W-1:0]  dwell,
    output logic [W-1:0]        out,
    output logic [SELW-1:0]     out_ch,
    output logic                out_valid,
    output logic                scan_wrap,
    output logic                busy
);

    localparam logic [SELW-1:0] C_LAST_CH = SELW'(NCH - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [SELW-1:0]      r_ch;
    logic [DWELL_W-1:0]   r_cnt;
    logic [DWELL_W-1:0]   r_dwell_q;
    logic [W-1:0]         r_out;
    logic [SELW-1:0]      r_out_ch;
    logic                 r_out_valid;
    logic                 r_scan_wrap;

    logic [SELW-1:0]      w_idx;
    logic [W-1:0]         w_data;
    logic                 w_in_range;
    logic                 w_start_scan;

    assign w_start_scan = start && (mode == MODE_SCAN);
    assign w_idx        = (r_state == ST_SCAN) ? r_ch : sel;

    mux_nto1 #(
        .NCH  (NCH),
        .W    (W),
        .SELW (SELW)
    ) u_sel (
        .in       (in),
        .idx      (w_idx),
        .data     (w_data),
        .in_range (w_in_range)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_start_scan)        w_state_nxt = ST_SCAN;
            ST_SCAN: if (mode == MODE_MANUAL) w_state_nxt = ST_IDLE;
            default:                          w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ch        <= '0;
            r_cnt       <= '0;
            r_dwell_q   <= '0;
            r_out       <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_scan_wrap <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_SCAN: begin
                    if (mode == MODE_MANUAL) begin
                        // Leaving scan drops any channel still in its dwell.
                        r_out_valid <= 1'b0;
                        r_scan_wrap <= 1'b0;
                    end else if (r_cnt != '0) begin
                        r_cnt       <= r_cnt - 1'b1;
                        r_out_valid <= 1'b0;
                        r_scan_wrap <= 1'b0;
                    end else begin
                        r_out       <= w_data;
                        r_out_ch    <= r_ch;
                        r_out_valid <= 1'b1;
                        r_scan_wrap <= (r_ch == C_LAST_CH);
                        r_ch        <= (r_ch == C_LAST_CH) ? '0 : r_ch + 1'b1;
                        r_cnt       <= r_dwell_q;
                    end
                end
                default: begin
                    r_scan_wrap <= 1'b0;
                    if (w_start_scan) begin
                        r_ch        <= '0;
                        r_cnt       <= dwell;
                        r_dwell_q   <= dwell;
                        r_out_valid <= 1'b0;
                    end else begin
                        r_out       <= w_data;
                        r_out_ch    <= sel;
                        r_out_valid <= w_in_range;
                    end
                end
            endcase
        end
    end

    assign out       = r_out;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;
    assign scan_wrap = r_scan_wrap;
    assign busy      = (r_state == ST_SCAN);

endmodule : mux_scan_nto1
`default_nettype wire

// File: tb/tb_mux_scan_nto1.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_scan_nto1
// Description : Directed bench for mux_scan_nto1 using three parameter sets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_scan_nto1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Instance A: NCH=16, W=1
    logic [15:0] a_in;
    logic [3:0]  a_sel, a_out_ch;
    logic        a_mode, a_start, a_out, a_valid, a_wrap, a_busy;
    logic [7:0]  a_dwell;

    // Instance B: NCH=12, W=8
    logic [95:0] b_in;
    logic [3:0]  b_sel, b_out_ch;
    logic        b_mode, b_start, b_valid, b_wrap, b_busy;
    logic [7:0]  b_dwell, b_out;

    // Instance C: NCH=4, W=4
    logic [15:0] c_in;
    logic [1:0]  c_sel, c_out_ch;
    logic        c_mode, c_start, c_valid, c_wrap, c_busy;
    logic [7:0]  c_dwell;
    logic [3:0]  c_out;

    mux_scan_nto1 #(.NCH(16), .W(1)) u_a (
        .clk(clk), .rst(rst), .in(a_in), .sel(a_sel), .mode(a_mode),
        .start(a_start), .dwell(a_dwell), .out(a_out), .out_ch(a_out_ch),
        .out_valid(a_valid), .scan_wrap(a_wrap), .busy(a_busy)
    );

    mux_scan_nto1 #(.NCH(12), .W(8)) u_b (
        .clk(clk), .rst(rst), .in(b_in), .sel(b_sel), .mode(b_mode),
        .start(b_start), .dwell(b_dwell), .out(b_out), .out_ch(b_out_ch),
        .out_valid(b_valid), .scan_wrap(b_wrap), .busy(b_busy)
    );

    mux_scan_nto1 #(.NCH(4), .W(4)) u_c (
        .clk(clk), .rst(rst), .in(c_in), .sel(c_sel), .mode(c_mode),
        .start(c_start), .dwell(c_dwell), .out(c_out), .out_ch(c_out_ch),
        .out_valid(c_valid), .scan_wrap(c_wrap), .busy(c_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_c(input string tag, input logic [3:0] o, input logic [1:0] ch,
                           input logic v, input logic w, input logic b);
        if (v) begin
            check({tag, ".out"},    c_out,    o);
            check({tag, ".out_ch"}, c_out_ch, ch);
        end
        check({tag, ".valid"}, c_valid, v);
        check({tag, ".wrap"},  c_wrap,  w);
        check({tag, ".busy"},  c_busy,  b);
    endtask

    logic [3:0] seq [4];

    initial begin
        seq[0] = 4'hA; seq[1] = 4'hB; seq[2] = 4'hC; seq[3] = 4'hD;

        rst = 1'b1;
        a_in = 16'h3f0a; a_sel = '0; a_mode = 1'b0; a_start = 1'b0; a_dwell = '0;
        b_in = '0;       b_sel = '0; b_mode = 1'b0; b_start = 1'b0; b_dwell = '0;
        c_in = 16'hDCBA; c_sel = '0; c_mode = 1'b0; c_start = 1'b0; c_dwell = '0;
        for (int k = 0; k < 12; k++) b_in[k*8 +: 8] = 8'(8'h10 + k);

        // Reset state
        tick();
        tick();
        check("rst.a_out",   a_out,    1'b0);
        check("rst.a_ch",    a_out_ch, 4'd0);
        check("rst.a_valid", a_valid,  1'b0);
        check("rst.b_out",   b_out,    8'h00);
        check("rst.b_valid", b_valid,  1'b0);
        check_c("rst.c", 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        check("rst.c_out",   c_out,    4'h0);
        check("rst.c_ch",    c_out_ch, 2'd0);
        rst = 1'b0;

        // Manual, 16x1, in=3f0a: sel 0,1,6,12 -> 0,1,0,1
        a_sel = 4'd0;  tick(); check("man.s0", a_out, 1'b0); check("man.s0.ch", a_out_ch, 4'd0);  check("man.s0.v", a_valid, 1'b1);
        a_sel = 4'd1;  tick(); check("man.s1", a_out, 1'b1); check("man.s1.ch", a_out_ch, 4'd1);  check("man.s1.v", a_valid, 1'b1);
        a_sel = 4'd6;  tick(); check("man.s6", a_out, 1'b0); check("man.s6.ch", a_out_ch, 4'd6);  check("man.s6.v", a_valid, 1'b1);
        a_sel = 4'd12; tick(); check("man.s12", a_out, 1'b1); check("man.s12.ch", a_out_ch, 4'd12); check("man.s12.v", a_valid, 1'b1);

        // Out-of-range, 12x8
        b_sel = 4'd13; tick();
        check("oor.13.out", b_out, 8'h00); check("oor.13.v", b_valid, 1'b0); check("oor.13.ch", b_out_ch, 4'd13);
        b_sel = 4'd11; tick();
        check("oor.11.out", b_out, 8'h1B); check("oor.11.v", b_valid, 1'b1); check("oor.11.ch", b_out_ch, 4'd11);
        b_sel = 4'd12; tick();
        check("oor.12.out", b_out, 8'h00); check("oor.12.v", b_valid, 1'b0);
        b_sel = 4'd0; tick();
        check("oor.0.out", b_out, 8'h10); check("oor.0.v", b_valid, 1'b1);

        // start with mode=0 is ignored
        c_sel = 2'd1; c_start = 1'b1; tick(); c_start = 1'b0;
        check_c("nostart", 4'hB, 2'd1, 1'b1, 1'b0, 1'b0);

        // Scan, dwell=0
        c_mode = 1'b1; c_dwell = 8'd0; c_start = 1'b1; tick(); c_start = 1'b0;
        check("d0.e0.busy",  c_busy,  1'b1);
        check("d0.e0.valid", c_valid, 1'b0);
        for (int e = 1; e <= 8; e++) begin
            tick();
            check_c($sformatf("d0.e%0d", e), seq[(e-1) % 4], 2'((e-1) % 4), 1'b1,
                    (e == 4 || e == 8), 1'b1);
        end
        c_mode = 1'b0; c_sel = 2'd2; tick();
        check_c("d0.exit", 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check_c("d0.manual", 4'hC, 2'd2, 1'b1, 1'b0, 1'b0);

        // Scan, dwell=2; dwell change at edge 4 and start at edge 7 ignored
        c_mode = 1'b1; c_dwell = 8'd2; c_start = 1'b1; tick(); c_start = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            if (e == 4) c_dwell = 8'd5;
            c_start = (e == 7);
            tick();
            check_c($sformatf("d2.e%0d", e), seq[(e/3 + 3) % 4], 2'((e/3 + 3) % 4),
                    (e % 3 == 0), (e == 12), 1'b1);
        end
        c_start = 1'b0;

        // Exit mid-dwell at edge 5, manual resumes at edge 6
        c_mode = 1'b0; tick();
        c_mode = 1'b1; c_dwell = 8'd2; c_start = 1'b1; tick(); c_start = 1'b0;
        tick(); tick(); tick();
        check_c("ex.e3", 4'hA, 2'd0, 1'b1, 1'b0, 1'b1);
        tick();
        check_c("ex.e4", 4'h0, 2'd0, 1'b0, 1'b0, 1'b1);
        c_mode = 1'b0; c_sel = 2'd1; tick();
        check_c("ex.e5", 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check_c("ex.e6", 4'hB, 2'd1, 1'b1, 1'b0, 1'b0);

        // Restart begins at channel 0
        c_mode = 1'b1; c_dwell = 8'd0; c_start = 1'b1; tick(); c_start = 1'b0;
        tick();
        check_c("rs.e1", 4'hA, 2'd0, 1'b1, 1'b0, 1'b1);
        tick();
        check_c("rs.e2", 4'hB, 2'd1, 1'b1, 1'b0, 1'b1);

        // Reset mid-scan
        rst = 1'b1; tick();
        check_c("rr.rst", 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        check("rr.out", c_out,    4'h0);
        check("rr.ch",  c_out_ch, 2'd0);
        rst = 1'b0; c_mode = 1'b0; c_sel = 2'd3; tick();
        check_c("rr.manual", 4'hD, 2'd3, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mux_scan_nto1
`default_nettype wire
